// File: rtl/motor_pwm_ramp.sv
// Soft-start/soft-stop PWM motor drive with estop hard stop and run-time watchdog fault.
// Latency: registered outputs; pwm follows pwm_cnt/duty one cycle later, state changes take effect on the next edge.
// Backpressure: none; en/estop are levels and clear is a pulse, all sampled every clk edge.
//
// Ports:
//   clk, reset   : system clock, synchronous active-high reset
//   en           : motor enable level from the toggle stage
//   estop        : debounced limit switch level; forces IDLE unless faulted
//   clear        : fault clear pulse, honoured only while en is low
//   pwm          : registered PWM drive
//   duty         : current duty
//   running      : high in RAMP_UP, RUN, RAMP_DOWN
//   fault        : watchdog fault latched
module motor_pwm_ramp #(
    parameter int PWM_BITS    = 8,
    parameter int PRESCALE    = 4,
    parameter int RAMP_CYCLES = 1000,
    parameter int STEP        = 8,
    parameter int DUTY_MAX    = 255,
    parameter int RUN_TIMEOUT = 50000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                estop,
    input  logic                clear,
    output logic                pwm,
    output logic [PWM_BITS-1:0] duty,
    output logic                running,
    output logic                fault
);

    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int RAMP_W = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;

    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [RAMP_W-1:0]   RAMP_LAST = RAMP_W'(RAMP_CYCLES - 1);
    localparam logic [31:0]         WD_LAST   = 32'(RUN_TIMEOUT - 1);
    localparam logic [PWM_BITS-1:0] DMAX      = PWM_BITS'(DUTY_MAX);
    // One extra bit so duty + STEP never wraps before the saturation compare.
    localparam logic [PWM_BITS:0]   DMAX_X    = {1'b0, DMAX};
    localparam logic [PWM_BITS:0]   STEP_X    = (PWM_BITS + 1)'(STEP);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAMP_UP,
        ST_RUN,
        ST_RAMP_DOWN,
        ST_FAULT
    } state_t;

    state_t              state, state_nxt;
    logic [PWM_BITS-1:0] duty_nxt;
    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [RAMP_W-1:0]   ramp_cnt, ramp_cnt_nxt;
    logic [31:0]         wd_cnt, wd_cnt_nxt;
    logic                ramp_tick;
    logic                driving;
    logic                estop_hit;
    logic [PWM_BITS:0]   up_sum;
    logic                pwm_nxt;

    // Next-state, duty and counter update.
    always_comb begin
        state_nxt    = state;
        duty_nxt     = duty;
        ramp_tick    = (ramp_cnt == RAMP_LAST);
        driving      = (state == ST_RAMP_UP) || (state == ST_RUN);
        estop_hit    = estop && (state != ST_FAULT);
        up_sum       = {1'b0, duty} + STEP_X;
        ramp_cnt_nxt = '0;
        wd_cnt_nxt   = '0;

        case (state)
            ST_IDLE: begin
                duty_nxt = '0;
                if (en) begin
                    state_nxt = ST_RAMP_UP;
                end
            end
            ST_RAMP_UP: begin
                // en falling wins over a coincident tick; duty is kept as-is.
                if (!en) begin
                    state_nxt = ST_RAMP_DOWN;
                end else if (ramp_tick) begin
                    if (up_sum >= DMAX_X) begin
                        duty_nxt  = DMAX;
                        state_nxt = ST_RUN;
                    end else begin
                        duty_nxt = up_sum[PWM_BITS-1:0];
                    end
                end
            end
            ST_RUN: begin
                duty_nxt = DMAX;
                if (!en) begin
                    state_nxt = ST_RAMP_DOWN;
                end
            end
            ST_RAMP_DOWN: begin
                if (en) begin
                    state_nxt = ST_RAMP_UP;
                end else if (ramp_tick) begin
                    if ({1'b0, duty} <= STEP_X) begin
                        duty_nxt  = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        duty_nxt = duty - STEP_X[PWM_BITS-1:0];
                    end
                end
            end
            ST_FAULT: begin
                duty_nxt = '0;
                if (clear && !en) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                duty_nxt  = '0;
                state_nxt = ST_IDLE;
            end
        endcase

        // Watchdog overrides the normal transitions, estop overrides everything.
        if (driving && (wd_cnt == WD_LAST)) begin
            state_nxt = ST_FAULT;
            duty_nxt  = '0;
        end
        if (estop_hit) begin
            state_nxt = ST_IDLE;
            duty_nxt  = '0;
        end

        if (driving) begin
            wd_cnt_nxt = wd_cnt + 32'd1;
        end

        // Ramp counter restarts on any transition so the first tick lands
        // RAMP_CYCLES edges after entering a ramp state.
        if ((state_nxt == state) &&
            ((state == ST_RAMP_UP) || (state == ST_RAMP_DOWN)) && !ramp_tick) begin
            ramp_cnt_nxt = ramp_cnt + RAMP_W'(1);
        end

        pwm_nxt = estop_hit ? 1'b0 : (pwm_cnt < duty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            duty     <= '0;
            pwm      <= 1'b0;
            running  <= 1'b0;
            fault    <= 1'b0;
            pre_cnt  <= '0;
            pwm_cnt  <= '0;
            ramp_cnt <= '0;
            wd_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            duty     <= duty_nxt;
            pwm      <= pwm_nxt;
            running  <= (state_nxt == ST_RAMP_UP) || (state_nxt == ST_RUN) ||
                        (state_nxt == ST_RAMP_DOWN);
            fault    <= (state_nxt == ST_FAULT);
            ramp_cnt <= ramp_cnt_nxt;
            wd_cnt   <= wd_cnt_nxt;
            // PWM timebase free-runs regardless of state.
            if (pre_cnt == PRE_LAST) begin
                pre_cnt <= '0;
                pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_motor_pwm_ramp.sv
// Bench for motor_pwm_ramp: directed test-plan sequence plus randomized en/estop/clear/reset.
// Latency: model updates on posedge, outputs compared on every negedge after the first reset.
// Backpressure: not applicable.
module tb_motor_pwm_ramp;

    localparam int PWM_BITS    = 8;
    localparam int PRESCALE    = 1;
    localparam int RAMP_CYCLES = 4;
    localparam int STEP        = 64;
    localparam int DUTY_MAX    = 255;
    localparam int RUN_TIMEOUT = 100;

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_RUN  = 2;
    localparam int M_DOWN = 3;
    localparam int M_FLT  = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                en;
    logic                estop;
    logic                clear;
    logic                pwm;
    logic [PWM_BITS-1:0] duty;
    logic                running;
    logic                fault;

    int n_tests = 0;
    int n_fail  = 0;

    motor_pwm_ramp #(
        .PWM_BITS   (PWM_BITS),
        .PRESCALE   (PRESCALE),
        .RAMP_CYCLES(RAMP_CYCLES),
        .STEP       (STEP),
        .DUTY_MAX   (DUTY_MAX),
        .RUN_TIMEOUT(RUN_TIMEOUT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .estop  (estop),
        .clear  (clear),
        .pwm    (pwm),
        .duty   (duty),
        .running(running),
        .fault  (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // age     : edges spent in the current state
    // drive   : edges spent continuously in RAMP_UP/RUN
    // phase   : edges since reset (PWM timebase)
    int m_st, m_duty, m_age, m_drive, m_phase;
    bit m_pwm, m_running, m_fault, m_valid = 1'b0;

    always @(posedge clk) begin : model
        int  cnt, nst, nduty;
        bit  npwm, tick, drv;
        if (reset) begin
            m_st = M_IDLE; m_duty = 0; m_pwm = 0; m_age = 0;
            m_drive = 0; m_phase = 0; m_running = 0; m_fault = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            cnt  = (m_phase / PRESCALE) % (1 << PWM_BITS);
            npwm = (cnt < m_duty);
            m_phase++;
            m_age++;
            drv = (m_st == M_UP) || (m_st == M_RUN);
            if (drv) m_drive++;
            else     m_drive = 0;
            tick  = ((m_st == M_UP) || (m_st == M_DOWN)) && (m_age % RAMP_CYCLES == 0);
            nst   = m_st;
            nduty = m_duty;
            if (estop && m_st != M_FLT) begin
                nst = M_IDLE; nduty = 0; npwm = 0;
            end else if (drv && m_drive >= RUN_TIMEOUT) begin
                nst = M_FLT; nduty = 0;
            end else begin
                case (m_st)
                    M_IDLE: if (en) nst = M_UP;
                    M_UP: begin
                        if (!en) nst = M_DOWN;
                        else if (tick) begin
                            nduty = (m_duty + STEP > DUTY_MAX) ? DUTY_MAX : m_duty + STEP;
                            if (nduty == DUTY_MAX) nst = M_RUN;
                        end
                    end
                    M_RUN:  if (!en) nst = M_DOWN;
                    M_DOWN: begin
                        if (en) nst = M_UP;
                        else if (tick) begin
                            nduty = (m_duty - STEP < 0) ? 0 : m_duty - STEP;
                            if (nduty == 0) nst = M_IDLE;
                        end
                    end
                    default: if (clear && !en) nst = M_IDLE;
                endcase
            end
            if (nst != m_st) m_age = 0;
            m_st      = nst;
            m_duty    = nduty;
            m_pwm     = npwm;
            m_running = (nst == M_UP) || (nst == M_RUN) || (nst == M_DOWN);
            m_fault   = (nst == M_FLT);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_duty",    int'(duty),    m_duty);
            check("cyc_pwm",     int'(pwm),     int'(m_pwm));
            check("cyc_running", int'(running), int'(m_running));
            check("cyc_fault",   int'(fault),   int'(m_fault));
        end
    end

    // Literal expectation on both DUT and model duty.
    task automatic lit_duty(input string name, input int exp);
        check(name, int'(duty), exp);
        check({name, "_model"}, m_duty, exp);
    endtask

    int up_exp[4];
    int down_exp[4];

    initial begin
        up_exp   = '{64, 128, 192, 255};
        down_exp = '{191, 127, 63, 0};

        // 1: reset held two cycles with en high
        reset = 1'b1; en = 1'b1; estop = 1'b0; clear = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_duty",    int'(duty),    0);
        check("rst_pwm",     int'(pwm),     0);
        check("rst_running", int'(running), 0);
        check("rst_fault",   int'(fault),   0);
        reset = 1'b0;
        @(negedge clk);
        check("t1_enter_up", int'(running), 1);
        lit_duty("t1_duty0", 0);

        // 2: ramp up 64,128,192,255 at 4-cycle intervals
        repeat (3) @(negedge clk);
        lit_duty("t2_no_early_tick", 0);
        @(negedge clk);
        lit_duty("t2_up0", up_exp[0]);
        for (int i = 1; i < 4; i++) begin
            repeat (4) @(negedge clk);
            lit_duty($sformatf("t2_up%0d", i), up_exp[i]);
        end
        check("t2_run_running", int'(running), 1);

        // 3: drop en in RUN, ramp down to IDLE
        en = 1'b0;
        @(negedge clk);
        lit_duty("t3_hold", 255);
        check("t3_running", int'(running), 1);
        for (int i = 0; i < 4; i++) begin
            repeat (4) @(negedge clk);
            lit_duty($sformatf("t3_down%0d", i), down_exp[i]);
        end
        check("t3_idle", int'(running), 0);

        // 4: estop mid-ramp at 128, hold with en=1, then release
        en = 1'b1;
        @(negedge clk);
        repeat (8) @(negedge clk);
        lit_duty("t4_mid", 128);
        estop = 1'b1;
        @(negedge clk);
        lit_duty("t4_estop_duty", 0);
        check("t4_estop_pwm", int'(pwm), 0);
        check("t4_estop_running", int'(running), 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_hold_idle", int'(running), 0);
        end
        estop = 1'b0;
        @(negedge clk);
        check("t4_resume", int'(running), 1);

        // 5: watchdog fires exactly 100 edges after RAMP_UP entry
        repeat (99) @(negedge clk);
        check("t5_no_early_fault", int'(fault), 0);
        @(negedge clk);
        check("t5_fault", int'(fault), 1);
        lit_duty("t5_fault_duty", 0);
        check("t5_fault_running", int'(running), 0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("t5_clear_ignored", int'(fault), 1);
        en = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("t5_cleared", int'(fault), 0);
        check("t5_cleared_running", int'(running), 0);

        // 6: en rises on a RAMP_DOWN tick edge at duty 192
        en = 1'b1;
        @(negedge clk);
        repeat (12) @(negedge clk);
        lit_duty("t6_at192", 192);
        en = 1'b0;
        @(negedge clk);
        lit_duty("t6_down_entry", 192);
        repeat (3) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        lit_duty("t6_tick_discarded", 192);
        check("t6_running", int'(running), 1);
        repeat (3) @(negedge clk);
        lit_duty("t6_no_early", 192);
        @(negedge clk);
        lit_duty("t6_reach_max", 255);

        // Randomized phase checked by the per-cycle model comparison.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 49) == 0) en = ~en;
            estop = ($urandom_range(0, 99) < 3);
            clear = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 999) == 0);
        end
        reset = 1'b0; estop = 1'b0; clear = 1'b0; en = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
